// File: rtl/jac1_sequencer.sv
// jac1_sequencer: multi-cycle fetch/wait/decode/execute/writeback control for
// the JAC1 core. Gates the decoder's raw write enables into one-cycle strobes,
// and provides run/halt, single-step, a halt-opcode trap and a retire counter.
module jac1_sequencer #(
  parameter int unsigned                NumOpCodeBits = 5,
  parameter int unsigned                MEM_WAIT      = 1,
  parameter logic [NumOpCodeBits-1:0]   HALT_OPCODE   = NumOpCodeBits'(5'h1F),
  parameter int unsigned                CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     run,
  input  logic                     step,
  input  logic [NumOpCodeBits-1:0] opcode,
  input  logic                     dec_wr_en,
  input  logic                     dec_cnt_wr_en,
  input  logic                     dec_stat_wr_en,
  output logic                     ir_load,
  output logic                     pc_inc,
  output logic                     pc_load,
  output logic                     rf_wr_en,
  output logic                     stat_wr_en,
  output logic                     halted,
  output logic                     trap,
  output logic [2:0]               state,
  output logic [CNT_WIDTH-1:0]     instr_count
);

  localparam int unsigned WaitW  = 4;
  localparam bit          NoWait = (MEM_WAIT == 0);

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_armed;
  logic                   r_step_q;
  logic                   r_single;
  logic                   w_single_nxt;
  logic [WaitW-1:0]       r_wait_cnt;
  logic [WaitW-1:0]       w_wait_nxt;
  logic                   r_trap;
  logic                   w_trap_nxt;
  logic [CNT_WIDTH-1:0]   r_instr_count;
  logic [CNT_WIDTH-1:0]   w_count_nxt;
  logic                   w_step_rise;

  // Step request is its rising edge against the previous sampled value.
  assign w_step_rise = step & ~r_step_q;

  assign state       = r_state;
  assign halted      = (r_state == ST_HALT) || (r_state == ST_TRAP);
  assign trap        = r_trap;
  assign instr_count = r_instr_count;

  // State register; r_armed delays the first transition to the second edge after reset release.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= ST_HALT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer side registers: arm flag, step edge, single-step, wait counter, trap, retire count.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_armed       <= 1'b0;
      r_step_q      <= 1'b0;
      r_single      <= 1'b0;
      r_wait_cnt    <= '0;
      r_trap        <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_armed       <= 1'b1;
      r_step_q      <= step;
      r_single      <= w_single_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_trap        <= w_trap_nxt;
      r_instr_count <= w_count_nxt;
    end
  end

  // Next-state and strobe decode from the registered state.
  always_comb begin
    w_state_nxt  = r_state;
    w_single_nxt = r_single;
    w_wait_nxt   = r_wait_cnt;
    w_trap_nxt   = r_trap;
    w_count_nxt  = r_instr_count;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    rf_wr_en     = 1'b0;
    stat_wr_en   = 1'b0;
    case (r_state)
      ST_HALT: begin
        w_single_nxt = 1'b0;
        if (r_armed) begin
          if (run) begin
            w_state_nxt = ST_FETCH;
          end else if (w_step_rise) begin
            w_state_nxt  = ST_FETCH;
            w_single_nxt = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        w_wait_nxt = WaitW'(MEM_WAIT);
        if (NoWait) begin
          ir_load     = 1'b1;
          w_state_nxt = ST_DECODE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_wait_nxt = r_wait_cnt - WaitW'(1);
        if (r_wait_cnt <= WaitW'(1)) begin
          ir_load     = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode == HALT_OPCODE) begin
          w_trap_nxt  = 1'b1;
          w_state_nxt = ST_TRAP;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        stat_wr_en  = dec_stat_wr_en;
        w_state_nxt = ST_WB;
      end
      ST_WB: begin
        rf_wr_en    = dec_wr_en;
        pc_load     = dec_cnt_wr_en;
        pc_inc      = ~dec_cnt_wr_en;
        w_count_nxt = r_instr_count + CNT_WIDTH'(1);
        if (!run || r_single) begin
          w_state_nxt  = ST_HALT;
          w_single_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_TRAP: begin
        w_state_nxt = ST_TRAP;
      end
      default: begin
        w_state_nxt = ST_HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_jac1_sequencer.sv
// Directed bench for jac1_sequencer: default instance (MEM_WAIT=1, 16-bit count)
// plus a MEM_WAIT=0, 4-bit-count instance for zero-wait latency and counter wrap.
module tb_jac1_sequencer;

  logic        clk = 1'b0;
  logic        res_n;
  logic        run;
  logic        run_b;
  logic        step;
  logic        step_b;
  logic [4:0]  opcode;
  logic        dec_wr_en;
  logic        dec_cnt_wr_en;
  logic        dec_stat_wr_en;

  logic        ir_load_a, pc_inc_a, pc_load_a, rf_wr_en_a, stat_wr_en_a, halted_a, trap_a;
  logic [2:0]  state_a;
  logic [15:0] count_a;
  logic        ir_load_b, pc_inc_b, pc_load_b, rf_wr_en_b, stat_wr_en_b, halted_b, trap_b;
  logic [2:0]  state_b;
  logic [3:0]  count_b;

  int n_checks = 0;
  int n_fail   = 0;
  int ph;
  logic strobe_seen;

  always #5 clk = ~clk;

  jac1_sequencer #(
    .NumOpCodeBits(5), .MEM_WAIT(1), .HALT_OPCODE(5'h1F), .CNT_WIDTH(16)
  ) u_dut_a (
    .clk(clk), .res_n(res_n), .run(run), .step(step), .opcode(opcode),
    .dec_wr_en(dec_wr_en), .dec_cnt_wr_en(dec_cnt_wr_en), .dec_stat_wr_en(dec_stat_wr_en),
    .ir_load(ir_load_a), .pc_inc(pc_inc_a), .pc_load(pc_load_a), .rf_wr_en(rf_wr_en_a),
    .stat_wr_en(stat_wr_en_a), .halted(halted_a), .trap(trap_a), .state(state_a),
    .instr_count(count_a)
  );

  jac1_sequencer #(
    .NumOpCodeBits(5), .MEM_WAIT(0), .HALT_OPCODE(5'h1F), .CNT_WIDTH(4)
  ) u_dut_b (
    .clk(clk), .res_n(res_n), .run(run_b), .step(step_b), .opcode(opcode),
    .dec_wr_en(dec_wr_en), .dec_cnt_wr_en(dec_cnt_wr_en), .dec_stat_wr_en(dec_stat_wr_en),
    .ir_load(ir_load_b), .pc_inc(pc_inc_b), .pc_load(pc_load_b), .rf_wr_en(rf_wr_en_b),
    .stat_wr_en(stat_wr_en_b), .halted(halted_b), .trap(trap_b), .state(state_b),
    .instr_count(count_b)
  );

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    res_n = 1'b0; run = 1'b0; run_b = 1'b0; step = 1'b0; step_b = 1'b0;
    opcode = 5'h00; dec_wr_en = 1'b0; dec_cnt_wr_en = 1'b0; dec_stat_wr_en = 1'b0;
    repeat (3) tick();

    // Reset values
    check_eq("rst_state",  32'(state_a),  32'd0);
    check_eq("rst_halted", 32'(halted_a), 32'd1);
    check_eq("rst_trap",   32'(trap_a),   32'd0);
    check_eq("rst_count",  32'(count_a),  32'd0);
    check_eq("rst_strobes", 32'({ir_load_a, pc_inc_a, pc_load_a, rf_wr_en_a, stat_wr_en_a}), 32'd0);

    // Release with run held: first transition on the second edge
    res_n = 1'b1; run = 1'b1; dec_wr_en = 1'b1; dec_stat_wr_en = 1'b1;
    tick();
    check_eq("rel_edge1_state", 32'(state_a), 32'd0);
    tick();
    check_eq("rel_edge2_state", 32'(state_a), 32'd1);
    check_eq("rel_edge2_halted", 32'(halted_a), 32'd0);

    // Three non-jump instructions, run dropped in EXEC of the third
    for (int i = 0; i < 15; i++) begin
      ph = i % 5;
      check_eq("t1_state",   32'(state_a),      32'(ph + 1));
      check_eq("t1_ir_load", 32'(ir_load_a),    32'(ph == 1));
      check_eq("t1_stat_wr", 32'(stat_wr_en_a), 32'(ph == 3));
      check_eq("t1_rf_wr",   32'(rf_wr_en_a),   32'(ph == 4));
      check_eq("t1_pc_inc",  32'(pc_inc_a),     32'(ph == 4));
      check_eq("t1_pc_load", 32'(pc_load_a),    32'd0);
      if (i == 13) run = 1'b0;
      tick();
    end
    check_eq("t1_end_state",  32'(state_a),  32'd0);
    check_eq("t1_end_halted", 32'(halted_a), 32'd1);
    check_eq("t1_end_count",  32'(count_a),  32'd3);

    // Single step of a jump instruction
    dec_wr_en = 1'b0; dec_stat_wr_en = 1'b0; dec_cnt_wr_en = 1'b1;
    step = 1'b1;
    tick();
    check_eq("t2_step1_state", 32'(state_a), 32'd1);
    step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t2_step1_seq", 32'(state_a), 32'(i + 2));
    end
    check_eq("t2_wb_pc_load", 32'(pc_load_a),  32'd1);
    check_eq("t2_wb_pc_inc",  32'(pc_inc_a),   32'd0);
    check_eq("t2_wb_rf_wr",   32'(rf_wr_en_a), 32'd0);
    tick();
    check_eq("t2_halt_state", 32'(state_a), 32'd0);
    check_eq("t2_halt_count", 32'(count_a), 32'd4);
    tick(); tick();
    check_eq("t2_gap_halted", 32'(halted_a), 32'd1);

    // Second step held high for 10 cycles retires only one instruction
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t2_hold_state", 32'(state_a), (i < 5) ? 32'(i + 1) : 32'd0);
    end
    check_eq("t2_hold_count", 32'(count_a), 32'd5);
    step = 1'b0;
    tick();

    // Halt opcode traps the core
    dec_cnt_wr_en = 1'b0; dec_wr_en = 1'b1; dec_stat_wr_en = 1'b1;
    opcode = 5'h1F; run = 1'b1;
    tick(); tick(); tick();
    check_eq("t3_decode_state", 32'(state_a), 32'd3);
    check_eq("t3_decode_trap",  32'(trap_a),  32'd0);
    tick();
    check_eq("t3_trap_state",  32'(state_a),  32'd6);
    check_eq("t3_trap_flag",   32'(trap_a),   32'd1);
    check_eq("t3_trap_halted", 32'(halted_a), 32'd1);
    strobe_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step = ~step;
      tick();
      strobe_seen = strobe_seen | ir_load_a | pc_inc_a | pc_load_a | rf_wr_en_a | stat_wr_en_a;
    end
    check_eq("t3_no_strobes", 32'(strobe_seen), 32'd0);
    check_eq("t3_still_trap", 32'(state_a),     32'd6);
    check_eq("t3_count",      32'(count_a),     32'd5);
    res_n = 1'b0;
    #1;
    check_eq("t3_rst_state", 32'(state_a), 32'd0);
    check_eq("t3_rst_trap",  32'(trap_a),  32'd0);
    check_eq("t3_rst_count", 32'(count_a), 32'd0);
    step = 1'b0; run = 1'b0; opcode = 5'h00;

    // Reset asserted during WAIT of the second instruction
    tick();
    res_n = 1'b1; run = 1'b1; dec_wr_en = 1'b1; dec_stat_wr_en = 1'b0;
    tick(); tick();
    repeat (5) tick();
    check_eq("t4_refetch_state", 32'(state_a), 32'd1);
    check_eq("t4_count_one",     32'(count_a), 32'd1);
    tick();
    check_eq("t4_wait_state", 32'(state_a),   32'd2);
    check_eq("t4_wait_irld",  32'(ir_load_a), 32'd1);
    res_n = 1'b0;
    #1;
    check_eq("t4_rst_state",   32'(state_a), 32'd0);
    check_eq("t4_rst_strobes", 32'({ir_load_a, pc_inc_a, pc_load_a, rf_wr_en_a, stat_wr_en_a}), 32'd0);
    check_eq("t4_rst_count",   32'(count_a), 32'd0);
    check_eq("t4_rst_halted",  32'(halted_a), 32'd1);
    run = 1'b0;

    // Zero-wait instance: 4-cycle latency, ir_load in FETCH, 4-bit count wraps
    tick();
    res_n = 1'b1; run_b = 1'b1;
    tick();
    check_eq("t5_arm_state", 32'(state_b), 32'd0);
    tick();
    check_eq("t5_fetch_state", 32'(state_b),   32'd1);
    check_eq("t5_fetch_irld",  32'(ir_load_b), 32'd1);
    tick();
    check_eq("t5_decode_state", 32'(state_b), 32'd3);
    tick();
    check_eq("t5_exec_stat", 32'(stat_wr_en_b), 32'd0);
    tick();
    check_eq("t5_wb_state", 32'(state_b),    32'd5);
    check_eq("t5_wb_rf_wr", 32'(rf_wr_en_b), 32'd1);
    tick();
    check_eq("t5_count_one", 32'(count_b), 32'd1);
    repeat (56) tick();
    check_eq("t5_count_15", 32'(count_b), 32'd15);
    check_eq("t5_state_15", 32'(state_b), 32'd1);
    repeat (4) tick();
    check_eq("t5_count_wrap", 32'(count_b), 32'd0);
    check_eq("t5_state_wrap", 32'(state_b), 32'd1);
    check_eq("t5_a_idle", 32'(state_a), 32'd0);
    run_b = 1'b0;
    repeat (6) tick();
    check_eq("t5_b_halted", 32'(halted_b), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jac1_sequencer.md
# jac1_sequencer

Multi-cycle instruction sequencer for the JAC1 core. It replaces free-running single-cycle execution with a registered fetch/wait/decode/execute/writeback state machine. It gates the decoder's raw write enables into one-cycle strobes for the program counter, register set and status register, and adds run/halt, single-step and a software halt trap. It sits between the decoder and the PC, register set and status register, and counts retired instructions.

## Interface
Parameters:
- NumOpCodeBits, 5, opcode width from the decoder
- MEM_WAIT, 1, program-memory wait cycles after FETCH (0..15)
- HALT_OPCODE, 5'h1F, opcode that traps the core
- CNT_WIDTH, 16, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, all state on rising edge
- res_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = execute continuously
- step  in  1  single-step request; rising edge is used, only while halted
- opcode  in  NumOpCodeBits  decoded opcode of the current instruction
- dec_wr_en  in  1  raw register-set write request from the decoder
- dec_cnt_wr_en  in  1  raw PC load (jump) request from the decoder
- dec_stat_wr_en  in  1  raw status write request from the decoder
- ir_load  out  1  capture program memory output into the instruction register
- pc_inc  out  1  advance PC by one
- pc_load  out  1  load PC from the literal/jump address
- rf_wr_en  out  1  register-set write strobe
- stat_wr_en  out  1  status-register write strobe
- halted  out  1  1 in HALT or TRAP
- trap  out  1  1 once HALT_OPCODE has executed; cleared only by reset
- state  out  3  current state code, for debug
- instr_count  out  CNT_WIDTH  retired instructions, wraps modulo 2^CNT_WIDTH

## Operation
- State codes: HALT=0, FETCH=1, WAIT=2, DECODE=3, EXEC=4, WB=5, TRAP=6. Code 7 is illegal and goes to HALT on the next clock.
- Reset (res_n=0, asynchronous):
  - state = HALT, instr_count = 0, trap = 0, step edge register = 0, single-step flag = 0, wait counter = 0.
  - All strobes = 0 and halted = 1.
- HALT:
  - run=1 → FETCH.
  - Otherwise, a step rising edge (step=1 while the previous sampled step was 0) → FETCH with the single-step flag set.
  - step is ignored while run=1 or outside HALT. The edge register still samples step every cycle.
- FETCH: load the wait counter with MEM_WAIT. Go to WAIT if MEM_WAIT>0, else to DECODE with ir_load=1 in this cycle.
- WAIT: decrement the counter. ir_load=1 in the cycle the counter equals 1, then go to DECODE.
- DECODE: if opcode==HALT_OPCODE → TRAP and set trap. Otherwise → EXEC. No strobes in this state.
- EXEC: stat_wr_en = dec_stat_wr_en. → WB.
- WB:
  - rf_wr_en = dec_wr_en.
  - pc_load = dec_cnt_wr_en and pc_inc = !dec_cnt_wr_en; exactly one of the two is 1.
  - instr_count increments.
  - Next state is HALT if run=0 or the single-step flag is set (the flag clears on entering HALT). Otherwise FETCH.
- TRAP: terminal until reset. All strobes are 0, PC is not advanced, and run and step are ignored.
- Strobes are combinational decodes of the registered state ANDed with the decoder inputs. They are 0 in every state not listed for them.
- Deasserting run mid-instruction does not abort: the instruction completes through WB, then the FSM enters HALT.

## Timing
- Instruction latency is 4+MEM_WAIT cycles from FETCH entry to WB exit: 5 cycles at the default, 4 at MEM_WAIT=0.
- ir_load is asserted exactly once per instruction, in the cycle immediately before DECODE.
- rf_wr_en, pc_inc/pc_load and the instr_count update occur in the same WB cycle. The new values are visible on the following edge.
- stat_wr_en occurs one cycle before WB, so status is updated before the register write.
- From HALT, run rising → FETCH on the next edge; halted falls in that same cycle.
- A step edge is sampled in cycle n and FETCH is entered at edge n+1. Exactly one instruction is retired per edge, even if step is held high.
- Reset asserted in any state forces HALT asynchronously; strobes drop in the same cycle. After release, the first transition is on the second rising edge after res_n goes high.

## Test plan
- Reset then run=1 with MEM_WAIT=1 and 3 non-jump instructions (dec_wr_en=1) → 3 rf_wr_en pulses 5 cycles apart, 3 pc_inc pulses, instr_count=3, state sequence 1,2,3,4,5 repeating.
- run=0 with step pulsed twice, the second pulse held high for 10 cycles → exactly 2 instructions retired, halted=1 between them, instr_count=2.
- Jump instruction with dec_cnt_wr_en=1 → pc_load=1 and pc_inc=0 in WB; non-jump → pc_inc=1 and pc_load=0.
- opcode=5'h1F in DECODE with run=1 → state=6, trap=1, halted=1, no further strobes for 20 cycles. Reset → trap=0, state=0.
- run dropped during EXEC → WB still completes with one rf_wr_en, then state=0. Reset asserted during WAIT → state=0 immediately, all strobes 0, instr_count=0.
- instr_count preset near wrap by running 65535 instructions, then one more → instr_count=0.
